// File: rtl/ibex_muldiv_seq_if.sv
// Request/response bundle for ibex_muldiv_seq: operation request handshake,
// pipeline kill, and the registered result handshake.
interface ibex_muldiv_seq_if #(
  parameter int unsigned Width = 32
) ();
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       op_i;
  logic [1:0]       signed_mode_i;
  logic [Width-1:0] op_a_i;
  logic [Width-1:0] op_b_i;
  logic             kill_i;
  logic             valid_o;
  logic             ready_i;
  logic [Width-1:0] result_o;
  logic             busy_o;

  modport master (
    output valid_i, op_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/ibex_muldiv_seq.sv
// Iterative multiplier/divider: one shift-add or restoring-subtract step per cycle.
// Optional macro IBEX_MULDIV_DIV_ZERO_FAST_EN answers divide-by-zero straight from IDLE.
module ibex_muldiv_seq #(
  parameter int unsigned Width    = 32,
  parameter bit          SignedEn = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  ibex_muldiv_seq_if.slave  bus
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [1:0] OpMul  = 2'd0;
  localparam logic [1:0] OpMulh = 2'd1;
  localparam logic [1:0] OpDiv  = 2'd2;
  localparam logic [1:0] OpRem  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_e;

  state_e               state_r, state_s;
  logic [1:0]           op_r;
  logic                 sign_a_r, sign_b_r, div_zero_r;
  logic [Width-1:0]     opnd_r;
  logic [2*Width-1:0]   acc_r;
  logic [CntW-1:0]      cnt_r;
  logic [Width-1:0]     result_r;
  logic                 valid_r, busy_r;

  logic                 accept_s, div_zero_in_s, sign_a_in_s, sign_b_in_s;
  logic [Width-1:0]     abs_a_in_s, abs_b_in_s;
  logic [Width:0]       mul_sum_s, div_shift_s, div_diff_s;
  logic [2*Width-1:0]   acc_step_s, prod_fix_s;
  logic [Width-1:0]     fix_res_s;

  assign bus.ready_o  = (state_r == IDLE) && !bus.kill_i;
  assign accept_s     = bus.valid_i && bus.ready_o;
  assign bus.valid_o  = valid_r;
  assign bus.busy_o   = busy_r;
  assign bus.result_o = result_r;

  // Operand decode: effective signs and magnitudes of the incoming request
  always_comb begin
    sign_a_in_s   = 1'b0;
    sign_b_in_s   = 1'b0;
    if (SignedEn) begin
      sign_a_in_s = bus.signed_mode_i[0] & bus.op_a_i[Width-1];
      sign_b_in_s = bus.signed_mode_i[1] & bus.op_b_i[Width-1];
    end else begin
      sign_a_in_s = 1'b0;
      sign_b_in_s = 1'b0;
    end
    abs_a_in_s    = sign_a_in_s ? -bus.op_a_i : bus.op_a_i;
    abs_b_in_s    = sign_b_in_s ? -bus.op_b_i : bus.op_b_i;
    div_zero_in_s = bus.op_i[1] && (bus.op_b_i == {Width{1'b0}});
  end

  // One iteration step; acc_r is {high/remainder, low/multiplier-or-quotient}
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*Width-1:Width]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(Width+1){1'b0}});
    div_shift_s = {acc_r[2*Width-1:Width], acc_r[Width-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    acc_step_s  = acc_r;
    if (!op_r[1]) begin
      acc_step_s = {mul_sum_s, acc_r[Width-1:1]};
    end else if (!div_diff_s[Width]) begin
      acc_step_s = {div_diff_s[Width-1:0], acc_r[Width-2:0], 1'b1};
    end else begin
      acc_step_s = {div_shift_s[Width-1:0], acc_r[Width-2:0], 1'b0};
    end
  end

  // Sign correction and result selection; a zero divisor forces an all-ones quotient
  always_comb begin
    prod_fix_s = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
    fix_res_s  = {Width{1'b0}};
    case (op_r)
      OpMul:   fix_res_s = prod_fix_s[Width-1:0];
      OpMulh:  fix_res_s = prod_fix_s[2*Width-1:Width];
      OpDiv: begin
        if (div_zero_r) begin
          fix_res_s = {Width{1'b1}};
        end else if (sign_a_r ^ sign_b_r) begin
          fix_res_s = -acc_r[Width-1:0];
        end else begin
          fix_res_s = acc_r[Width-1:0];
        end
      end
      OpRem:   fix_res_s = sign_a_r ? -acc_r[2*Width-1:Width] : acc_r[2*Width-1:Width];
      default: fix_res_s = {Width{1'b0}};
    endcase
  end

  // Next-state logic; kill overrides every state
  always_comb begin
    state_s = state_r;
    if (bus.kill_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
`ifdef IBEX_MULDIV_DIV_ZERO_FAST_EN
            state_s = div_zero_in_s ? OUT : CALC;
`else
            state_s = CALC;
`endif
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == {CntW{1'b0}}) begin
            state_s = FIX;
          end else begin
            state_s = CALC;
          end
        end
        FIX:  state_s = OUT;
        OUT: begin
          if (bus.ready_i) begin
            state_s = IDLE;
          end else begin
            state_s = OUT;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      op_r       <= 2'd0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      div_zero_r <= 1'b0;
      opnd_r     <= {Width{1'b0}};
      acc_r      <= {(2*Width){1'b0}};
      cnt_r      <= {CntW{1'b0}};
      result_r   <= {Width{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      valid_r <= (state_s == OUT);
      busy_r  <= (state_s != IDLE);
      if (accept_s) begin
        op_r       <= bus.op_i;
        sign_a_r   <= sign_a_in_s;
        sign_b_r   <= sign_b_in_s;
        div_zero_r <= div_zero_in_s;
        opnd_r     <= bus.op_i[1] ? abs_b_in_s : abs_a_in_s;
        acc_r      <= {{Width{1'b0}}, (bus.op_i[1] ? abs_a_in_s : abs_b_in_s)};
        cnt_r      <= CntW'(Width - 1);
      end else if (state_r == CALC) begin
        acc_r <= acc_step_s;
        if (cnt_r != {CntW{1'b0}}) begin
          cnt_r <= cnt_r - CntW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        acc_r <= acc_r;
      end
      if (state_r == FIX && state_s == OUT) begin
        result_r <= fix_res_s;
`ifdef IBEX_MULDIV_DIV_ZERO_FAST_EN
      end else if (accept_s && state_s == OUT) begin
        result_r <= (bus.op_i == OpDiv) ? {Width{1'b1}} : bus.op_a_i;
`endif
      end else begin
        result_r <= result_r;
      end
    end
  end

endmodule

// File: tb/tb_ibex_muldiv_seq.sv
// Scoreboard bench for ibex_muldiv_seq (Width=32): directed vectors, latency,
// kill/reset abort and output back-pressure.
module tb_ibex_muldiv_seq;

  localparam logic [1:0] OP_MUL = 2'd0, OP_MULH = 2'd1, OP_DIV = 2'd2, OP_REM = 2'd3;
  localparam int LAT = 34;
`ifdef IBEX_MULDIV_DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 34;
`endif

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  ibex_muldiv_seq_if #(.Width(32)) bus ();

  ibex_muldiv_seq #(.Width(32), .SignedEn(1'b1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each new result and checks hold stability
  initial begin
    exp_t        e;
    logic        prev_valid = 1'b0;
    logic [31:0] held = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.valid_o && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(bus.valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, 64'(bus.result_o), 64'(e.res));
          chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
        end
        held = bus.result_o;
      end else if (bus.valid_o && prev_valid) begin
        chk("result_hold", 64'(bus.result_o), 64'(held));
      end
      prev_valid = bus.valid_o;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (bus.busy_o) chk({name, "_idle_timeout"}, 64'(bus.busy_o), 64'd0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit push, input bit wait_done, input string name);
    int   n = 0;
    exp_t e;
    @(posedge clk);
    #1;
    bus.valid_i       = 1'b1;
    bus.op_i          = op;
    bus.signed_mode_i = sm;
    bus.op_a_i        = a;
    bus.op_b_i        = b;
    @(negedge clk);
    while (!bus.ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.ready_o) begin
      chk({name, "_accept_timeout"}, 64'(bus.ready_o), 64'd1);
    end else if (push) begin
      e.res = exp; e.lat = lat; e.acc_cyc = cyc; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    if (wait_done) wait_idle(name);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.valid_i = 1'b0; bus.op_i = 2'd0; bus.signed_mode_i = 2'd0;
    bus.op_a_i = 32'h0; bus.op_b_i = 32'h0; bus.kill_i = 1'b0; bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_result", 64'(bus.result_o), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);

    issue(OP_MUL,  2'd3, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT,    1, 1, "mul_signed");
    issue(OP_MULH, 2'd3, 32'h80000000, 32'h80000000, 32'h40000000, LAT,    1, 1, "mulh_ss_minmin");
    issue(OP_MULH, 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, LAT,    1, 1, "mulh_uu_minmin");
    issue(OP_MULH, 2'd0, 32'hFFFFFFFF, 32'h2,        32'h1,        LAT,    1, 1, "mulh_uu_max2");
    issue(OP_MUL,  2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        LAT,    1, 1, "mul_uu_max");
    issue(OP_MULH, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT,    1, 1, "mulh_uu_max");
    issue(OP_MULH, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        LAT,    1, 1, "mulh_ss_m1m1");
    issue(OP_MULH, 2'd1, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, LAT,    1, 1, "mulh_su");
    issue(OP_DIV,  2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT,    1, 1, "div_overflow");
    issue(OP_REM,  2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        LAT,    1, 1, "rem_overflow");
    issue(OP_REM,  2'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, LAT,    1, 1, "rem_neg");
    issue(OP_DIV,  2'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, LAT,    1, 1, "div_neg");
    issue(OP_DIV,  2'd0, 32'd100,      32'd7,        32'd14,       LAT,    1, 1, "div_uu");
    issue(OP_REM,  2'd0, 32'd100,      32'd7,        32'd2,        LAT,    1, 1, "rem_uu");
    issue(OP_DIV,  2'd0, 32'd5,        32'h0,        32'hFFFFFFFF, DZ_LAT, 1, 1, "div_zero_u");
    issue(OP_DIV,  2'd3, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, DZ_LAT, 1, 1, "div_zero_s");
    issue(OP_REM,  2'd3, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, DZ_LAT, 1, 1, "rem_zero_s");

    // Kill at CALC iteration 10
    issue(OP_MUL, 2'd0, 32'd5, 32'd6, 32'd0, LAT, 0, 0, "kill_op");
    repeat (9) @(posedge clk);
    #1; bus.kill_i = 1'b1;
    @(posedge clk); #1; bus.kill_i = 1'b0;
    @(negedge clk);
    chk("kill_valid", 64'(bus.valid_o), 64'd0);
    chk("kill_busy", 64'(bus.busy_o), 64'd0);
    chk("kill_ready", 64'(bus.ready_o), 64'd1);
    repeat (40) @(negedge clk);
    issue(OP_MUL, 2'd0, 32'd3, 32'd4, 32'd12, LAT, 1, 1, "mul_after_kill");

    // Reset while in CALC
    issue(OP_MUL, 2'd0, 32'd5, 32'd6, 32'd0, LAT, 0, 0, "reset_op");
    repeat (9) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("calc_rst_valid", 64'(bus.valid_o), 64'd0);
    chk("calc_rst_busy", 64'(bus.busy_o), 64'd0);
    chk("calc_rst_ready", 64'(bus.ready_o), 64'd1);
    chk("calc_rst_result", 64'(bus.result_o), 64'd0);
    repeat (40) @(negedge clk);
    issue(OP_MUL, 2'd0, 32'd3, 32'd4, 32'd12, LAT, 1, 1, "mul_after_reset");

    // Back-pressure in OUT
    bus.ready_i = 1'b0;
    issue(OP_DIV, 2'd0, 32'd100, 32'd7, 32'd14, LAT, 1, 0, "div_backpressure");
    n = 0;
    @(negedge clk);
    while (!bus.valid_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.valid_o) chk("bp_valid_timeout", 64'(bus.valid_o), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", 64'(bus.valid_o), 64'd1);
      chk("bp_ready_low", 64'(bus.ready_o), 64'd0);
    end
    @(posedge clk); #1; bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", 64'(bus.valid_o), 64'd0);
    chk("bp_release_busy", 64'(bus.busy_o), 64'd0);
    chk("bp_release_ready", 64'(bus.ready_o), 64'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
